// File: rtl/bcd_disp_feeder.sv
// bcd_disp_feeder
//   Minisys-1 IO-bus peripheral. Converts a 32-bit unsigned binary value into
//   8 packed BCD digits by sequential double-dabble (one bit per cycle). It can
//   then push the digits and a leading-zero-blanking enable mask to the 7-segment
//   display controller's register port.
//   All state changes on negedge clk, matching the bus timing.
//   Optional hex passthrough (CTL bit2): define BCD_DISP_FEEDER_HEX_EN.
module bcd_disp_feeder #(
  parameter logic [3:0] SEG_DATA_LO_ADDR = 4'h0,
  parameter logic [3:0] SEG_DATA_HI_ADDR = 4'h2,
  parameter logic [3:0] SEG_CTL_ADDR     = 4'h4
) (
  input  logic        clk,
  input  logic        isReset,
  input  logic        isCS,
  input  logic        isW,
  input  logic [3:0]  addr,
  input  logic [15:0] dR,
  output logic [15:0] dW,
  output logic        seg_cs,
  output logic        seg_w,
  output logic [3:0]  seg_addr,
  output logic [15:0] seg_data
);

  localparam logic [3:0] REG_BIN_LO = 4'h0;
  localparam logic [3:0] REG_BIN_HI = 4'h2;
  localparam logic [3:0] REG_CTL    = 4'h4;
  localparam logic [3:0] REG_BCD_LO = 4'h6;
  localparam logic [3:0] REG_BCD_HI = 4'h8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_PUSH_LO,
    S_PUSH_HI,
    S_PUSH_CTL
  } state_e;

  state_e      state;
  logic [31:0] bin;        // CPU-visible BIN register
  logic [31:0] work;       // binary shift register consumed by the conversion
  logic [39:0] acc;        // 10-digit BCD accumulator
  logic [31:0] result;     // CPU-visible BCD result
  logic [4:0]  cnt;        // remaining iterations after the current one
  logic        done;
  logic        ovf;
  logic        autopush;
  logic        hex_mode;

  logic        busy;
  logic        cpu_wr;
  logic        start;
  logic [39:0] acc_adj;
  logic [39:0] acc_next;
  logic [31:0] work_next;
  logic        ovf_next;
  logic [31:0] res_conv;
  logic [15:0] rdata;
  logic        rd_hit;

  // Digit-enable mask with leading-zero blanking: digit i is lit when any digit
  // at position >= i is nonzero; the rightmost digit is always lit.
  function automatic logic [7:0] digit_mask(input logic [31:0] v);
    logic seen;
    seen       = 1'b0;
    digit_mask = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      seen          = seen | (v[4*i +: 4] != 4'h0);
      digit_mask[i] = seen;
    end
    digit_mask[0] = 1'b1;
  endfunction

  assign busy   = (state != S_IDLE);
  assign cpu_wr = isCS && isW;
  assign start  = cpu_wr && (addr == REG_CTL) && dR[0] && (state == S_IDLE);

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, bin}.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // update, so no path leaves it unassigned and no latch is inferred.
    acc_adj = acc;
    for (int i = 0; i < 10; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    {acc_next, work_next} = {acc_adj, work} << 1;
    ovf_next = (acc_next[39:32] != 8'h00);
    res_conv = ovf_next ? 32'h9999_9999 : acc_next[31:0];
  end

  // CPU-writable configuration: BIN halves and the CTL mode bits.
  always_ff @(negedge clk or posedge isReset) begin
    // NOTE: clocked state uses non-blocking assignments so every register sees
    // pre-edge values of the others, independent of block ordering.
    if (isReset) begin
      bin      <= '0;
      autopush <= 1'b0;
`ifdef BCD_DISP_FEEDER_HEX_EN
      hex_mode <= 1'b0;
`endif
    end else if (cpu_wr) begin
      case (addr)
        REG_BIN_LO: bin[15:0]  <= dR;
        REG_BIN_HI: bin[31:16] <= dR;
        REG_CTL: begin
          autopush <= dR[1];
`ifdef BCD_DISP_FEEDER_HEX_EN
          hex_mode <= dR[2];
`endif
        end
        default: ;
      endcase
    end
  end

`ifndef BCD_DISP_FEEDER_HEX_EN
  assign hex_mode = 1'b0;
`endif

  // Conversion / push sequencer with registered display-bus outputs.
  always_ff @(negedge clk or posedge isReset) begin
    if (isReset) begin
      state    <= S_IDLE;
      work     <= '0;
      acc      <= '0;
      result   <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      seg_cs   <= 1'b0;
      seg_w    <= 1'b0;
      seg_addr <= '0;
      seg_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
`ifdef BCD_DISP_FEEDER_HEX_EN
            if (dR[2]) begin
              // Hex passthrough: result is BIN as-is, ready on this edge.
              result <= bin;
              ovf    <= 1'b0;
              done   <= 1'b1;
              if (dR[1]) begin
                state    <= S_PUSH_LO;
                seg_cs   <= 1'b1;
                seg_w    <= 1'b1;
                seg_addr <= SEG_DATA_LO_ADDR;
                seg_data <= bin[15:0];
              end
            end else begin
              work  <= bin;
              acc   <= '0;
              cnt   <= 5'd31;
              done  <= 1'b0;
              ovf   <= 1'b0;
              state <= S_CONV;
            end
`else
            work  <= bin;
            acc   <= '0;
            cnt   <= 5'd31;
            done  <= 1'b0;
            ovf   <= 1'b0;
            state <= S_CONV;
`endif
          end
        end

        S_CONV: begin
          work <= work_next;
          acc  <= acc_next;
          if (cnt != 5'd0) begin
            cnt <= cnt - 5'd1;
          end else begin
            ovf    <= ovf_next;
            result <= res_conv;
            done   <= 1'b1;
            if (autopush) begin
              // Strobe goes up with the state so it is held for the whole
              // PUSH_LO cycle and sampled by the display on the next negedge.
              state    <= S_PUSH_LO;
              seg_cs   <= 1'b1;
              seg_w    <= 1'b1;
              seg_addr <= SEG_DATA_LO_ADDR;
              seg_data <= res_conv[15:0];
            end else begin
              state <= S_IDLE;
            end
          end
        end

        S_PUSH_LO: begin
          state    <= S_PUSH_HI;
          seg_addr <= SEG_DATA_HI_ADDR;
          seg_data <= result[31:16];
        end

        S_PUSH_HI: begin
          state    <= S_PUSH_CTL;
          seg_addr <= SEG_CTL_ADDR;
          seg_data <= {digit_mask(result), 8'h00};
        end

        S_PUSH_CTL: begin
          state    <= S_IDLE;
          seg_cs   <= 1'b0;
          seg_w    <= 1'b0;
          seg_addr <= '0;
          seg_data <= '0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // CPU read mux; reflects register contents before the coming edge.
  always_comb begin
    rdata  = 16'h0000;
    rd_hit = 1'b1;
    case (addr)
      REG_BIN_LO: rdata = bin[15:0];
      REG_BIN_HI: rdata = bin[31:16];
      REG_CTL:    rdata = {busy, ovf, 11'd0, hex_mode, autopush, done};
      REG_BCD_LO: rdata = result[15:0];
      REG_BCD_HI: rdata = result[31:16];
      default:    rd_hit = 1'b0;
    endcase
  end

  assign dW = (isCS && !isW && rd_hit) ? rdata : 16'hzzzz;

endmodule

// File: tb/tb_bcd_disp_feeder.sv
// Self-checking bench for bcd_disp_feeder: directed cases with literal
// expectations plus randomized bus traffic against a transaction-level model.
module tb_bcd_disp_feeder;

  logic        clk;
  logic        isReset;
  logic        isCS;
  logic        isW;
  logic [3:0]  addr;
  logic [15:0] dR;
  logic [15:0] dW;
  logic        seg_cs;
  logic        seg_w;
  logic [3:0]  seg_addr;
  logic [15:0] seg_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  logic [19:0] push_q[$];
  int          push_cyc[$];

  bcd_disp_feeder dut (
    .clk      (clk),
    .isReset  (isReset),
    .isCS     (isCS),
    .isW      (isW),
    .addr     (addr),
    .dR       (dR),
    .dW       (dW),
    .seg_cs   (seg_cs),
    .seg_w    (seg_w),
    .seg_addr (seg_addr),
    .seg_data (seg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic void ref_convert(input logic [31:0] v, output logic [31:0] r, output bit o);
    longint unsigned x;
    r = '0;
    o = (v > 32'd99999999);
    if (o) begin
      r = 32'h9999_9999;
    end else begin
      x = longint'(v);
      for (int i = 0; i < 8; i++) begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
  endfunction

  // Highest nonzero digit position decides how many digits are lit.
  function automatic logic [7:0] ref_mask(input logic [31:0] r);
    int top = 0;
    for (int i = 0; i < 8; i++) if (r[4*i +: 4] != 4'h0) top = i;
    return 8'((1 << (top + 1)) - 1);
  endfunction

  logic [31:0] m_bin, m_work, m_res;
  bit          m_done, m_ovf, m_ap, m_hex;
  int          m_conv_left, m_push_left;

  function automatic logic [15:0] model_read(input logic [3:0] a);
    bit b;
    b = (m_conv_left > 0) || (m_push_left > 0);
    case (a)
      4'h0:    return m_bin[15:0];
      4'h2:    return m_bin[31:16];
      4'h4:    return {b, m_ovf, 11'd0, m_hex, m_ap, m_done};
      4'h6:    return m_res[15:0];
      4'h8:    return m_res[31:16];
      default: return 16'h0000;
    endcase
  endfunction

  // Model advances on the same edges as the design, from pre-edge values.
  initial begin
    forever begin
      @(negedge clk or posedge isReset);
      if (isReset) begin
        m_bin = '0; m_work = '0; m_res = '0;
        m_done = 0; m_ovf = 0; m_ap = 0; m_hex = 0;
        m_conv_left = 0; m_push_left = 0;
      end else begin
        bit was_busy, ap_old, o;
        logic [31:0] r;
        was_busy = (m_conv_left > 0) || (m_push_left > 0);
        ap_old   = m_ap;
        if (m_conv_left > 0) begin
          m_conv_left--;
          if (m_conv_left == 0) begin
            ref_convert(m_work, r, o);
            m_res = r; m_ovf = o; m_done = 1;
            m_push_left = ap_old ? 3 : 0;
          end
        end else if (m_push_left > 0) begin
          m_push_left--;
        end
        if (isCS && isW) begin
          case (addr)
            4'h0: m_bin[15:0]  = dR;
            4'h2: m_bin[31:16] = dR;
            4'h4: begin
              m_ap = dR[1];
`ifdef BCD_DISP_FEEDER_HEX_EN
              m_hex = dR[2];
`endif
              if (!was_busy && dR[0]) begin
`ifdef BCD_DISP_FEEDER_HEX_EN
                if (dR[2]) begin
                  m_res = m_bin; m_ovf = 0; m_done = 1;
                  m_push_left = dR[1] ? 3 : 0;
                end else begin
                  m_work = m_bin; m_conv_left = 32; m_done = 0; m_ovf = 0;
                end
`else
                m_work = m_bin; m_conv_left = 32; m_done = 0; m_ovf = 0;
`endif
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    forever begin
      @(posedge clk);
      cycle++;
      #2;
      begin
        bit exp_stb;
        exp_stb = (m_push_left > 0);
        check("seg_cs", 32'(seg_cs), 32'(exp_stb));
        check("seg_w",  32'(seg_w),  32'(exp_stb));
        if (exp_stb) begin
          case (m_push_left)
            3:       begin check("seg_addr_lo", 32'(seg_addr), 32'h0); check("seg_data_lo", 32'(seg_data), 32'(m_res[15:0])); end
            2:       begin check("seg_addr_hi", 32'(seg_addr), 32'h2); check("seg_data_hi", 32'(seg_data), 32'(m_res[31:16])); end
            default: begin check("seg_addr_ctl", 32'(seg_addr), 32'h4); check("seg_data_ctl", 32'(seg_data), {16'h0, ref_mask(m_res), 8'h00}); end
          endcase
        end
        if (seg_cs && seg_w) begin
          push_q.push_back({seg_addr, seg_data});
          push_cyc.push_back(cycle);
        end
        if (isCS && !isW && (addr inside {4'h0, 4'h2, 4'h4, 4'h6, 4'h8}))
          check($sformatf("read_%0h", addr), 32'(dW), 32'(model_read(addr)));
      end
    end
  end

  // ---------------- bus driver tasks (one bus cycle each) ----------------
  task automatic op_idle();
    @(posedge clk);
    isCS = 0; isW = 0; addr = 4'h0; dR = 16'h0;
  endtask

  task automatic op_wr(input logic [3:0] a, input logic [15:0] d);
    @(posedge clk);
    isCS = 1; isW = 1; addr = a; dR = d;
  endtask

  task automatic op_rd(input logic [3:0] a);
    @(posedge clk);
    isCS = 1; isW = 0; addr = a; dR = 16'h0;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [15:0] exp);
    op_rd(a);
    #1;
    check(name, 32'(dW), 32'(exp));
  endtask

  task automatic load_bin(input logic [31:0] v);
    op_wr(4'h0, v[15:0]);
    op_wr(4'h2, v[31:16]);
  endtask

  // Poll DONE; returns the number of polls until it reads 1.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 100; k++) begin
      op_rd(4'h4);
      #1;
      if (dW[0] === 1'b1) begin
        cyc = k;
        break;
      end
    end
    if (cyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: DONE not seen within 100 cycles");
    end
  endtask

  task automatic clear_push();
    push_q.delete();
    push_cyc.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          cyc;
    logic [31:0] r;
    bit          o;

    isCS = 0; isW = 0; addr = 4'h0; dR = 16'h0;
    isReset = 0;
    #1 isReset = 1;
    repeat (3) @(posedge clk);
    #1 isReset = 0;

    // Literal pins on the reference model itself
    ref_convert(32'd1234, r, o);
    check("model_1234", r, 32'h0000_1234);
    ref_convert(32'd100000000, r, o);
    check("model_ovf", {31'd0, o}, 32'd1);
    check("model_mask", 32'(ref_mask(32'h0000_1234)), 32'h0F);

    // Reset state
    rd_chk("rst_stat", 4'h4, 16'h0000);
    rd_chk("rst_bcd_lo", 4'h6, 16'h0000);
    check("rst_seg_cs", 32'(seg_cs), 32'd0);

    // Reset in the middle of a conversion
    load_bin(32'd777);
    op_wr(4'h4, 16'h0001);
    repeat (9) op_idle();
    @(posedge clk);
    isCS = 1; isW = 0; addr = 4'h4; dR = 16'h0;
    #1 isReset = 1;
    #1;
    check("midrst_seg_cs", 32'(seg_cs), 32'd0);
    check("midrst_stat", 32'(dW), 32'h0000);
    @(posedge clk);
    #1 isReset = 0;
    load_bin(32'd42);
    op_wr(4'h4, 16'h0001);
    wait_done(cyc);
    check("latency", cyc, 33);
    rd_chk("bcd_42", 4'h6, 16'h0042);

    // 1234 with autopush
    clear_push();
    load_bin(32'd1234);
    op_wr(4'h4, 16'h0003);
    wait_done(cyc);
    repeat (4) op_idle();
    check("push_count", push_q.size(), 3);
    if (push_q.size() == 3) begin
      check("push0", 32'(push_q[0]), {12'h0, 4'h0, 16'h1234});
      check("push1", 32'(push_q[1]), {12'h0, 4'h2, 16'h0000});
      check("push2", 32'(push_q[2]), {12'h0, 4'h4, 16'h0F00});
      check("push_span", push_cyc[2] - push_cyc[0], 2);
    end
    rd_chk("bcd_lo_1234", 4'h6, 16'h1234);
    rd_chk("bcd_hi_1234", 4'h8, 16'h0000);
    rd_chk("stat_1234", 4'h4, 16'h0003);

    // Zero
    clear_push();
    load_bin(32'd0);
    op_wr(4'h4, 16'h0003);
    wait_done(cyc);
    repeat (4) op_idle();
    if (push_q.size() == 3) check("ctl_zero", 32'(push_q[2][15:0]), 32'h0100);
    else check("push_count_zero", push_q.size(), 3);
    rd_chk("bcd_lo_zero", 4'h6, 16'h0000);

    // Largest representable value
    clear_push();
    load_bin(32'd99999999);
    op_wr(4'h4, 16'h0003);
    wait_done(cyc);
    repeat (4) op_idle();
    if (push_q.size() == 3) check("ctl_max", 32'(push_q[2][15:0]), 32'hFF00);
    else check("push_count_max", push_q.size(), 3);
    rd_chk("bcd_lo_max", 4'h6, 16'h9999);
    rd_chk("bcd_hi_max", 4'h8, 16'h9999);
    rd_chk("stat_max", 4'h4, 16'h0003);

    // Overflow cases
    load_bin(32'd100000000);
    op_wr(4'h4, 16'h0001);
    wait_done(cyc);
    rd_chk("stat_ovf1", 4'h4, 16'h4001);
    rd_chk("bcd_lo_ovf1", 4'h6, 16'h9999);
    rd_chk("bcd_hi_ovf1", 4'h8, 16'h9999);
    load_bin(32'hFFFF_FFFF);
    op_wr(4'h4, 16'h0001);
    wait_done(cyc);
    rd_chk("stat_ovf2", 4'h4, 16'h4001);
    rd_chk("bcd_lo_ovf2", 4'h6, 16'h9999);

    // Writes while busy: new BIN accepted, START ignored
    load_bin(32'd777);
    op_wr(4'h4, 16'h0001);
    op_idle();
    load_bin(32'd5);
    op_wr(4'h4, 16'h0001);
    wait_done(cyc);
    rd_chk("busy_result", 4'h6, 16'h0777);
    rd_chk("bin_kept", 4'h0, 16'h0005);
    op_wr(4'h4, 16'h0001);
    wait_done(cyc);
    rd_chk("next_result", 4'h6, 16'h0005);

`ifdef BCD_DISP_FEEDER_HEX_EN
    clear_push();
    load_bin(32'h00AB_CDEF);
    op_wr(4'h4, 16'h0007);
    wait_done(cyc);
    check("hex_latency", cyc, 1);
    repeat (4) op_idle();
    if (push_q.size() == 3) check("hex_ctl", 32'(push_q[2][15:0]), 32'h3F00);
    else check("push_count_hex", push_q.size(), 3);
    rd_chk("hex_lo", 4'h6, 16'hCDEF);
    rd_chk("hex_hi", 4'h8, 16'h00AB);
`endif

    // Randomized bus traffic, checked every cycle by the compare process
    for (int n = 0; n < 2500; n++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 25) begin
        op_idle();
      end else if (sel < 40) begin
        case ($urandom_range(0, 3))
          0:       op_wr(4'h0, 16'hE0FF);
          1:       op_wr(4'h0, 16'hE100);
          2:       op_wr(4'h0, 16'($urandom_range(0, 99)));
          default: op_wr(4'h0, 16'($urandom));
        endcase
      end else if (sel < 55) begin
        case ($urandom_range(0, 3))
          0:       op_wr(4'h2, 16'h0000);
          1:       op_wr(4'h2, 16'h05F5);
          2:       op_wr(4'h2, 16'($urandom_range(0, 16'h05F5)));
          default: op_wr(4'h2, 16'($urandom));
        endcase
      end else if (sel < 70) begin
        op_wr(4'h4, 16'($urandom_range(0, 7)));
      end else begin
        op_rd(4'($urandom_range(0, 15)));
      end
    end
    repeat (50) op_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_disp_feeder.md
Name: bcd_disp_feeder

Overview:
- Memory-mapped peripheral on the Minisys-1 IO bus that converts a 32-bit unsigned binary value into 8 packed BCD digits by sequential double-dabble.
- Sits directly upstream of the 7-segment display controller. It acts as a bus master on that controller's register port and pushes the digit word and the digit-enable/decimal-point control word.
- Lets software show decimal numbers with a single start write instead of a software division loop.

Parameters:
- SEG_DATA_LO_ADDR, 4'h0, display register address for digits 3..0.
- SEG_DATA_HI_ADDR, 4'h2, display register address for digits 7..4.
- SEG_CTL_ADDR, 4'h4, display control register address. High byte is the digit-enable mask (bit15 = leftmost digit); low byte is the decimal points.

Ports:
- clk  input  1  system clock. All sequential logic updates on negedge clk, matching bus timing.
- isReset  input  1  asynchronous, active-high reset.
- isCS  input  1  chip select from the CPU-side address decoder.
- isW  input  1  1 = write, 0 = read.
- addr  input  4  register offset.
- dR  input  16  write data from the CPU.
- dW  output  16  read data to the CPU. 16'hzzzz unless isCS && !isW && addr is valid.
- seg_cs  output  1  chip select to the display controller.
- seg_w  output  1  write strobe to the display controller.
- seg_addr  output  4  display register address.
- seg_data  output  16  write data to the display controller.

Behaviour:
- CPU register map:
  - 0x0 BIN_LO (rw)
  - 0x2 BIN_HI (rw)
  - 0x4 CTL/STAT. Write: bit0 START, bit1 AUTOPUSH. Read: bit15 BUSY, bit14 OVF, bit1 AUTOPUSH, bit0 DONE.
  - 0x6 BCD_LO (r)
  - 0x8 BCD_HI (r)
  - Other addresses: reads return z, writes are ignored.
- Reset (asynchronous, any time including mid-conversion or mid-push):
  - FSM goes to IDLE. BIN, BCD, OVF, DONE, AUTOPUSH and the iteration counter are cleared.
  - seg_cs = 0, seg_w = 0, seg_addr = 0, seg_data = 0.
- FSM states: IDLE, CONV, PUSH_LO, PUSH_HI, PUSH_CTL.
- IDLE:
  - A write to CTL with bit0 = 1 captures BIN into a working shift register.
  - Clears DONE and OVF, clears the 40-bit BCD accumulator, and loads the counter with 31. Goes to CONV.
  - The AUTOPUSH bit is written on every CTL write.
- CONV:
  - One iteration per cycle: add 3 to each 4-bit BCD nibble ≥ 5, then shift {bcd, bin} left by 1.
  - Exactly 32 cycles.
  - On the last cycle, OVF = (BCD digits 9..8 != 0).
  - BCD_LO/HI take the low 32 accumulator bits. If OVF, they saturate to 32'h99999999.
  - DONE is set. Next state is PUSH_LO if AUTOPUSH, else IDLE.
- PUSH_LO / PUSH_HI / PUSH_CTL:
  - One cycle each. seg_cs = 1 and seg_w = 1, with seg_addr/seg_data set to the LO digits, HI digits, and control word respectively.
  - The strobe is held a full cycle so the display samples it on the following negedge. Strobes are low in every other state.
  - Control word = {enable mask, 8'h00}.
  - Enable mask: leading-zero blanking. The digit at position i is enabled iff some digit at position ≥ i is nonzero. The rightmost digit (bit8) is always enabled.
  - After PUSH_CTL, go to IDLE.
- Latency: START written at negedge N.
  - CONV covers edges N+1..N+32. DONE and BCD are readable after N+32.
  - Push strobes occur at N+33..N+35. BUSY = 1 from N+1 until leaving PUSH_CTL.
- Writes while busy:
  - BIN writes are accepted and do not disturb the working copy.
  - START is ignored. The AUTOPUSH bit is updated but only sampled at the end of CONV.
- A CPU read and an internal state change on the same edge: the read returns the pre-edge value.

Optional Feature:
- Macro: BCD_DISP_FEEDER_HEX_EN.
- Defined: CTL bit2 (HEX) becomes rw.
  - START with HEX = 1 copies BIN straight into BCD and skips CONV; OVF = 0. DONE and BUSY timing shrinks to 1 cycle (IDLE→PUSH_LO or IDLE).
  - Enable mask uses the same nonzero rule on hex nibbles.
- Undefined: CTL bit2 reads 0, writes to it are ignored, no hex path exists.

Test Plan:
- Reset mid-CONV: assert isReset at cycle 10 → BUSY = 0, DONE = 0, seg_cs = 0 immediately; a later START with BIN = 42 and AUTOPUSH = 0 gives BCD_LO = 16'h0042 after 32 cycles.
- BIN = 1234, AUTOPUSH = 1, START → BCD_LO = 16'h1234, BCD_HI = 0, OVF = 0. Push sequence: (0x0,16'h1234), (0x2,16'h0000), (0x4,16'h0F00) on three consecutive cycles.
- BIN = 0, AUTOPUSH = 1 → BCD = 0, control push = 16'h0100. BIN = 99999999 → BCD = 32'h99999999, control = 16'hFF00, OVF = 0.
- BIN = 100000000 and BIN = 32'hFFFFFFFF → OVF = 1, BCD = 32'h99999999, DONE = 1.
- Write BIN = 5 and START during CONV of 777 → result 0x777, START ignored; next START converts 5.
- With BCD_DISP_FEEDER_HEX_EN: BIN = 32'h00ABCDEF, HEX = 1, AUTOPUSH = 1 → BCD = 32'h00ABCDEF in 1 cycle, push control = 16'h3F00.
